// File: rtl/dcache_direct_mapped.sv
// Direct-mapped, write-through, no-write-allocate L1 data cache with a fixed-latency memory port.
// Optional hit/miss counters are built when DCACHE_STATS_EN is defined.
module dcache_direct_mapped #(
    parameter int WORD_SIZE   = 16,
    parameter int LINE_WORDS  = 4,
    parameter int NUM_LINES   = 4,
    parameter int MEM_LATENCY = 4
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            cpu_read,
    input  logic                            cpu_write,
    input  logic [WORD_SIZE-1:0]            cpu_address,
    input  logic [WORD_SIZE-1:0]            cpu_wdata,
    output logic [WORD_SIZE-1:0]            cpu_rdata,
    output logic                            cpu_hit,
    output logic                            cpu_write_done,
    input  logic                            bus_granted,
    output logic                            mem_read,
    output logic                            mem_write,
    output logic [WORD_SIZE-1:0]            mem_address,
    output logic [WORD_SIZE-1:0]            mem_wdata,
    input  logic [LINE_WORDS*WORD_SIZE-1:0] mem_rdata
`ifdef DCACHE_STATS_EN
    ,
    output logic [15:0]                     stat_hits,
    output logic [15:0]                     stat_misses
`endif
);

    // state | meaning
    // IDLE  | serve hits, accept new store or read miss
    // FILL  | holding mem_read for MEM_LATENCY un-granted cycles, then install the line
    // WRITE | holding mem_write for MEM_LATENCY un-granted cycles, update on hit

    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = WORD_SIZE - OFF_W - IDX_W;
    localparam int CNT_W = $clog2(MEM_LATENCY) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [NUM_LINES-1:0] valid;
    logic [TAG_W-1:0]     tags [NUM_LINES];
    logic [WORD_SIZE-1:0] data [NUM_LINES][LINE_WORDS];

    logic [CNT_W-1:0]     counter;
    logic                 replay;
    logic [WORD_SIZE-1:0] lat_addr;
    logic [WORD_SIZE-1:0] lat_data;

    logic [OFF_W-1:0] cpu_off;
    logic [IDX_W-1:0] cpu_idx;
    logic [TAG_W-1:0] cpu_tag;
    logic [OFF_W-1:0] lat_off;
    logic [IDX_W-1:0] lat_idx;
    logic [TAG_W-1:0] lat_tag;
    logic             cpu_match;
    logic             lat_match;

    logic start_write;
    logic start_fill;
    logic fill_done;
    logic write_done;
    logic count_up;

    assign cpu_off   = cpu_address[OFF_W-1:0];
    assign cpu_idx   = cpu_address[OFF_W+IDX_W-1:OFF_W];
    assign cpu_tag   = cpu_address[WORD_SIZE-1:OFF_W+IDX_W];
    assign lat_off   = lat_addr[OFF_W-1:0];
    assign lat_idx   = lat_addr[OFF_W+IDX_W-1:OFF_W];
    assign lat_tag   = lat_addr[WORD_SIZE-1:OFF_W+IDX_W];
    assign cpu_match = valid[cpu_idx] && (tags[cpu_idx] == cpu_tag);
    assign lat_match = valid[lat_idx] && (tags[lat_idx] == lat_tag);

    // Outputs are forced low while reset is asserted so nothing leaks out of an aborted operation.
    always_comb begin
        state_next     = state;
        cpu_hit        = 1'b0;
        cpu_rdata      = '0;
        cpu_write_done = 1'b0;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        mem_address    = '0;
        mem_wdata      = '0;
        start_write    = 1'b0;
        start_fill     = 1'b0;
        fill_done      = 1'b0;
        write_done     = 1'b0;
        count_up       = 1'b0;
        if (reset_n) begin
            case (state)
                IDLE: begin
                    if (cpu_write) begin
                        start_write = 1'b1;
                        state_next  = WRITE;
                    end else if (cpu_read) begin
                        if (cpu_match) begin
                            cpu_hit   = 1'b1;
                            cpu_rdata = data[cpu_idx][cpu_off];
                        end else begin
                            start_fill = 1'b1;
                            state_next = FILL;
                        end
                    end
                end
                FILL: begin
                    if (!bus_granted) begin
                        mem_read    = 1'b1;
                        mem_address = lat_addr;
                        if (counter == CNT_LAST) begin
                            fill_done  = 1'b1;
                            state_next = IDLE;
                        end else begin
                            count_up = 1'b1;
                        end
                    end
                end
                WRITE: begin
                    if (!bus_granted) begin
                        mem_write   = 1'b1;
                        mem_address = lat_addr;
                        mem_wdata   = lat_data;
                        if (counter == CNT_LAST) begin
                            cpu_write_done = 1'b1;
                            write_done     = 1'b1;
                            state_next     = IDLE;
                        end else begin
                            count_up = 1'b1;
                        end
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= IDLE;
            counter  <= '0;
            replay   <= 1'b0;
            valid    <= '0;
            lat_addr <= '0;
            lat_data <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE) begin
                replay <= 1'b0;
            end
            if (start_write) begin
                lat_addr <= cpu_address;
                lat_data <= cpu_wdata;
                counter  <= '0;
            end
            if (start_fill) begin
                lat_addr <= {cpu_address[WORD_SIZE-1:OFF_W], {OFF_W{1'b0}}};
                counter  <= '0;
            end
            if (count_up) begin
                counter <= counter + CNT_W'(1);
            end
            if (fill_done) begin
                valid[lat_idx] <= 1'b1;
                replay         <= 1'b1;
            end
        end
    end

    // Tag and data arrays need no reset: the valid bits qualify them.
    always_ff @(posedge clk) begin
        if (fill_done) begin
            tags[lat_idx] <= lat_tag;
            for (int w = 0; w < LINE_WORDS; w++) begin
                data[lat_idx][w] <= mem_rdata[w*WORD_SIZE +: WORD_SIZE];
            end
        end else if (write_done && lat_match) begin
            data[lat_idx][lat_off] <= lat_data;
        end
    end

`ifdef DCACHE_STATS_EN
    logic count_hit;

    // The hit that replays a just-filled read belongs to the miss, so it is not counted.
    assign count_hit = reset_n && (state == IDLE) && cpu_read && cpu_match && !replay;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stat_hits   <= '0;
            stat_misses <= '0;
        end else begin
            if (count_hit && (stat_hits != 16'hFFFF)) begin
                stat_hits <= stat_hits + 16'd1;
            end
            if (start_fill && (stat_misses != 16'hFFFF)) begin
                stat_misses <= stat_misses + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dcache_direct_mapped.sv
// Bench for dcache_direct_mapped: a table of cache operations checked through a scoreboard,
// plus hand-written reset-abort sequences.
module tb_dcache_direct_mapped;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cpu_read = 1'b0;
    logic        cpu_write = 1'b0;
    logic [15:0] cpu_address = '0;
    logic [15:0] cpu_wdata = '0;
    logic [15:0] cpu_rdata;
    logic        cpu_hit;
    logic        cpu_write_done;
    logic        bus_granted = 1'b0;
    logic        mem_read;
    logic        mem_write;
    logic [15:0] mem_address;
    logic [15:0] mem_wdata;
    logic [63:0] mem_rdata;
`ifdef DCACHE_STATS_EN
    logic [15:0] stat_hits;
    logic [15:0] stat_misses;
`endif

    int errors = 0;
    int checks = 0;

    logic [15:0] mem [0:65535];
    logic [15:0] base;

    always #5 clk = ~clk;

    dcache_direct_mapped dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .cpu_read       (cpu_read),
        .cpu_write      (cpu_write),
        .cpu_address    (cpu_address),
        .cpu_wdata      (cpu_wdata),
        .cpu_rdata      (cpu_rdata),
        .cpu_hit        (cpu_hit),
        .cpu_write_done (cpu_write_done),
        .bus_granted    (bus_granted),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_address    (mem_address),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata)
`ifdef DCACHE_STATS_EN
        ,
        .stat_hits      (stat_hits),
        .stat_misses    (stat_misses)
`endif
    );

    // Backing memory: presents the whole line while a fill is requested.
    assign base      = {mem_address[15:2], 2'b00};
    assign mem_rdata = mem_read ? {mem[base + 16'd3], mem[base + 16'd2], mem[base + 16'd1], mem[base]} : 64'h0;

    typedef struct {
        bit          wr;
        logic [15:0] addr;
        logic [15:0] data;
        logic [15:0] exp;
        int          lat;
        int          memcyc;
        int          dma_at;
        int          dma_len;
    } vec_t;

    typedef struct {
        logic [15:0] data;
        int          lat;
        int          memcyc;
    } exp_t;

    vec_t vecs [14];
    exp_t sb [$];

    function automatic logic [15:0] pat(input logic [15:0] a);
        return a ^ 16'hA5C3;
    endfunction

    function automatic vec_t mk(input bit wr, input logic [15:0] addr, input logic [15:0] data,
                                input logic [15:0] exp, input int lat, input int memcyc,
                                input int dma_at, input int dma_len);
        vec_t v;
        v.wr = wr; v.addr = addr; v.data = data; v.exp = exp;
        v.lat = lat; v.memcyc = memcyc; v.dma_at = dma_at; v.dma_len = dma_len;
        return v;
    endfunction

    function automatic bit in_dma(input vec_t v, input int cyc);
        return (v.dma_len > 0) && (cyc >= v.dma_at) && (cyc < v.dma_at + v.dma_len);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one request, hold it until the DUT reports completion, then score it.
    task automatic run_op(input vec_t v, input string tag);
        exp_t        e;
        int          cyc;
        int          mc;
        int          bad;
        bit          done;
        logic [15:0] got;
        e.data = v.exp; e.lat = v.lat; e.memcyc = v.memcyc;
        sb.push_back(e);
        cyc = 0; mc = 0; bad = 0; done = 1'b0; got = '0;
        @(posedge clk); #1;
        cpu_read    = !v.wr;
        cpu_write   = v.wr;
        cpu_address = v.addr;
        cpu_wdata   = v.data;
        bus_granted = in_dma(v, 0);
        while (!done && cyc < 40) begin
            @(negedge clk);
            if (mem_read) begin
                mc++;
                if (v.wr || mem_address != {v.addr[15:2], 2'b00}) bad++;
            end
            if (mem_write) begin
                mc++;
                if (!v.wr || mem_address != v.addr || mem_wdata != v.data) bad++;
                mem[mem_address] = mem_wdata;
            end
            if (bus_granted && (mem_read || mem_write || mem_address != 16'h0 || mem_wdata != 16'h0)) bad++;
            if (v.wr ? cpu_write_done : cpu_hit) begin
                done = 1'b1;
                got  = cpu_rdata;
            end else begin
                @(posedge clk); #1;
                cyc++;
                bus_granted = in_dma(v, cyc);
            end
        end
        @(posedge clk); #1;
        cpu_read = 1'b0; cpu_write = 1'b0; bus_granted = 1'b0;
        e = sb.pop_front();
        chk({tag, "_done"}, done, 1'b1);
        chk({tag, "_latency"}, cyc, e.lat);
        chk({tag, "_mem_cycles"}, mc, e.memcyc);
        chk({tag, "_bus_ok"}, bad, 0);
        if (!v.wr) chk({tag, "_rdata"}, got, e.data);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    initial begin
        for (int a = 0; a < 65536; a++) begin
            mem[a] = pat(16'(a));
        end
        mem[16'h0010] = 16'h000A;
        mem[16'h0011] = 16'h000B;
        mem[16'h0012] = 16'h000C;
        mem[16'h0013] = 16'h000D;

        //                wr  addr      wdata     expected        lat mc dma_at len
        vecs[0]  = mk(0, 16'h0012, 16'h0000, 16'h000C,       5, 4, 0, 0);
        vecs[1]  = mk(0, 16'h0013, 16'h0000, 16'h000D,       0, 0, 0, 0);
        vecs[2]  = mk(0, 16'h0110, 16'h0000, pat(16'h0110),  5, 4, 0, 0);
        vecs[3]  = mk(0, 16'h0010, 16'h0000, 16'h000A,       5, 4, 0, 0);
        vecs[4]  = mk(1, 16'h0011, 16'h5A5A, 16'h0000,       4, 4, 0, 0);
        vecs[5]  = mk(0, 16'h0011, 16'h0000, 16'h5A5A,       0, 0, 0, 0);
        vecs[6]  = mk(1, 16'h0020, 16'h1234, 16'h0000,       4, 4, 0, 0);
        vecs[7]  = mk(0, 16'h0010, 16'h0000, 16'h000A,       0, 0, 0, 1);
        vecs[8]  = mk(0, 16'h0020, 16'h0000, 16'h1234,       5, 4, 0, 0);
        vecs[9]  = mk(0, 16'h0036, 16'h0000, pat(16'h0036),  8, 4, 2, 3);
        vecs[10] = mk(0, 16'h0035, 16'h0000, pat(16'h0035),  0, 0, 0, 0);
        vecs[11] = mk(1, 16'h0037, 16'hBEEF, 16'h0000,       6, 4, 1, 2);
        vecs[12] = mk(0, 16'h0037, 16'h0000, 16'hBEEF,       0, 0, 0, 0);
        vecs[13] = mk(0, 16'h0022, 16'h0000, pat(16'h0022),  0, 0, 0, 0);

        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        chk("reset_cpu_hit", cpu_hit, 1'b0);
        chk("reset_write_done", cpu_write_done, 1'b0);
        chk("reset_rdata", cpu_rdata, 16'h0);
        chk("reset_mem_read", mem_read, 1'b0);
        chk("reset_mem_write", mem_write, 1'b0);
        chk("reset_mem_address", mem_address, 16'h0);
`ifdef DCACHE_STATS_EN
        chk("reset_stat_hits", stat_hits, 16'h0);
        chk("reset_stat_misses", stat_misses, 16'h0);
`endif

        for (int i = 0; i < 14; i++) begin
            run_op(vecs[i], $sformatf("vec%0d", i));
`ifdef DCACHE_STATS_EN
            if (i == 1) begin
                chk("stat_misses_first", stat_misses, 16'd1);
                chk("stat_hits_first", stat_hits, 16'd1);
            end
`endif
        end

        chk("mem_0011", mem[16'h0011], 16'h5A5A);
        chk("mem_0020", mem[16'h0020], 16'h1234);
        chk("mem_0037", mem[16'h0037], 16'hBEEF);

        // Reset asserted during the second fill cycle aborts the fill.
        @(posedge clk); #1;
        cpu_read = 1'b1; cpu_address = 16'h0042;
        @(posedge clk); #1;
        @(negedge clk);
        chk("abort_fill_started", mem_read, 1'b1);
        @(posedge clk); #1;
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1; cpu_read = 1'b0;
        @(negedge clk);
        chk("abort_mem_read", mem_read, 1'b0);
        chk("abort_cpu_hit", cpu_hit, 1'b0);
        run_op(mk(0, 16'h0042, 16'h0000, pat(16'h0042), 5, 4, 0, 0), "reread_after_abort");
        run_op(mk(0, 16'h0010, 16'h0000, 16'h000A, 5, 4, 0, 0), "valid_cleared");

        // Reset during a store abandons it: no completion, memory port released.
        @(posedge clk); #1;
        cpu_write = 1'b1; cpu_address = 16'h0013; cpu_wdata = 16'h7777;
        @(posedge clk); #1;
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1; cpu_write = 1'b0;
        @(negedge clk);
        chk("abort_mem_write", mem_write, 1'b0);
        chk("abort_write_done", cpu_write_done, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
